// File: rtl/cpu_pkg.sv
// cpu_pkg: datapath widths and the register address type shared by decode, ALU and register file
package cpu_pkg;
  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 2 ** ADDR_W;
  typedef logic [ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/register_file.sv
// register_file: 16x16 register file, one synchronous write port, two asynchronous read ports
module register_file
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_write_en,
  input  reg_addr_t         reg_write_dest,
  input  logic [DATA_W-1:0] reg_write_data,
  input  reg_addr_t         reg_read_addr_1,
  output logic [DATA_W-1:0] reg_read_data_1,
  input  reg_addr_t         reg_read_addr_2,
  output logic [DATA_W-1:0] reg_read_data_2
);
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    assign regs_d[i] = (reg_write_en && reg_write_dest == reg_addr_t'(i)) ? reg_write_data : regs_q[i];
    always_ff @(posedge clk) begin
      if (rst) regs_q[i] <= '0;
      else     regs_q[i] <= regs_d[i];
    end
  end
  // reads see stored state only, so a same-address write appears after the edge
  assign reg_read_data_1 = regs_q[reg_read_addr_1];
  assign reg_read_data_2 = regs_q[reg_read_addr_2];
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed stimulus against an array model of the register file
module tb_register_file;
  import cpu_pkg::*;
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              we = 1'b0;
  reg_addr_t         dest = '0;
  logic [DATA_W-1:0] wdata = '0;
  reg_addr_t         a1 = '0;
  reg_addr_t         a2 = '0;
  logic [DATA_W-1:0] rd1, rd2;
  logic [DATA_W-1:0] m [NUM_REGS];
  logic              mv = 1'b0;
  int                total = 0;
  int                passed = 0;

  register_file dut (
    .clk            (clk),
    .rst            (rst),
    .reg_write_en   (we),
    .reg_write_dest (dest),
    .reg_write_data (wdata),
    .reg_read_addr_1(a1),
    .reg_read_data_1(rd1),
    .reg_read_addr_2(a2),
    .reg_read_data_2(rd2)
  );

  always #5 clk = ~clk;

  // reference: reset clears everything and wins; otherwise an enabled write stores data
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) m[i] <= '0;
      mv <= 1'b1;
    end else if (we) m[dest] <= wdata;
  end

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (mv) begin
      check("model_port1", rd1, m[a1]);
      check("model_port2", rd2, m[a2]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reg_addr_t a;
    step();
    rst = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      step();
      a1 = reg_addr_t'(i);
      a2 = reg_addr_t'(NUM_REGS - 1 - i);
      #1;
      check("reset_p1", rd1, 16'h0000);
      check("reset_p2", rd2, 16'h0000);
    end
    step();
    we = 1'b1; dest = 4'd3; wdata = 16'hABCD;
    step();
    we = 1'b0; a1 = 4'd3; a2 = 4'd3;
    #1;
    check("wr_r3_p1", rd1, 16'hABCD);
    check("wr_r3_p2", rd2, 16'hABCD);
    step();
    we = 1'b0; dest = 4'd5; wdata = 16'h1234;
    step();
    a1 = 4'd5;
    #1;
    check("en_low_r5", rd1, 16'h0000);
    step();
    a1 = 4'd7; we = 1'b1; dest = 4'd7; wdata = 16'h5A5A;
    #1;
    check("rdw_before", rd1, 16'h0000);
    step();
    we = 1'b0;
    #1;
    check("rdw_after", rd1, 16'h5A5A);
    for (int i = 0; i < NUM_REGS; i++) begin
      step();
      we = 1'b1; dest = reg_addr_t'(i); wdata = 16'h1000 + 16'(i);
    end
    step();
    we = 1'b0;
    a = '0;
    for (int i = 0; i <= NUM_REGS; i++) begin
      step();
      a1 = a;
      a2 = reg_addr_t'(NUM_REGS - 1 - (i % NUM_REGS));
      #1;
      check("sweep_asc", rd1, 16'h1000 + 16'(i % NUM_REGS));
      check("sweep_desc", rd2, 16'h1000 + 16'(NUM_REGS - 1 - (i % NUM_REGS)));
      a = a + 1'b1;
    end
    check("wrap_r0", rd1, 16'h1000);
    step();
    rst = 1'b1; we = 1'b1; dest = 4'd2; wdata = 16'hFFFF;
    step();
    rst = 1'b0; we = 1'b0; a1 = 4'd2; a2 = 4'd15;
    #1;
    check("rst_prio_r2", rd1, 16'h0000);
    check("rst_clears_rf", rd2, 16'h0000);
    step();
    step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
